// File: rtl/hdmi_rx_pkg.sv
// Shared constants and helpers for the HDMI data-island packet receiver.
package hdmi_rx_pkg;

  localparam logic [7:0] PKT_NULL         = 8'h00;
  localparam logic [7:0] PKT_ACR          = 8'h01;
  localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
  localparam logic [7:0] PKT_AVI          = 8'h82;
  localparam logic [7:0] PKT_SPD          = 8'h83;
  localparam logic [7:0] PKT_AUDIO_INFO   = 8'h84;

  localparam logic [7:0] AVI_VERSION = 8'h02;
  localparam logic [7:0] AVI_LENGTH  = 8'h0D;

  typedef enum logic {ST_IDLE, ST_UNPACK} unpack_state_t;

  function automatic logic [7:0] sub_byte(input logic [55:0] s, input int n);
    return s[8*n +: 8];
  endfunction

endpackage

// File: rtl/hdmi_rx_audio_fifo.sv
// First-word fall-through FIFO holding unpacked stereo audio entries.
module hdmi_rx_audio_fifo #(
  parameter int WIDTH      = 33,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_pop;
  logic                  w_push;

  assign o_empty = (r_count == '0);
  // Count never exceeds DEPTH, so its MSB alone marks full.
  assign o_full  = r_count[DEPTH_LOG2];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hdmi_packet_receiver.sv
// Classifies corrected data-island packets: audio unpack into a FIFO,
// ACR N/CTS capture, AVI InfoFrame checksum and VIC extraction.
module hdmi_packet_receiver
  import hdmi_rx_pkg::*;
#(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                            i_clk_pixel,
  input  logic                            i_reset,
  input  logic                            i_packet_valid,
  input  logic [23:0]                     i_header,
  input  logic [3:0][55:0]                i_sub,
  input  logic                            i_header_ecc_error,
  input  logic [3:0]                      i_sub_ecc_error,
  input  logic                            i_audio_ready,
  output logic                            o_audio_valid,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0] o_audio_sample_word,
  output logic                            o_audio_block_start,
  output logic                            o_audio_overflow,
  output logic                            o_parity_error,
  output logic [19:0]                     o_acr_n,
  output logic [19:0]                     o_acr_cts,
  output logic                            o_acr_update,
  output logic [6:0]                      o_avi_vic,
  output logic                            o_avi_valid,
  output logic [15:0]                     o_ecc_error_count
);

  localparam int W  = AUDIO_BIT_WIDTH;
  localparam int FW = 2 * W + 1;

  logic [7:0] w_hb0, w_hb1, w_hb2;
  logic       w_hdr_ok, w_is_audio, w_is_acr, w_is_avi;

  assign w_hb0 = i_header[7:0];
  assign w_hb1 = i_header[15:8];
  assign w_hb2 = i_header[23:16];

  assign w_hdr_ok   = i_packet_valid && !i_header_ecc_error;
  assign w_is_audio = w_hdr_ok && (w_hb0 == PKT_AUDIO_SAMPLE) && !w_hb1[4];
  assign w_is_acr   = w_hdr_ok && (w_hb0 == PKT_ACR) && !i_sub_ecc_error[0];
  assign w_is_avi   = w_hdr_ok && (w_hb0 == PKT_AVI) && (w_hb1 == AVI_VERSION) &&
                      (w_hb2 == AVI_LENGTH) && (i_sub_ecc_error == '0);

  // Audio unpacker
  unpack_state_t    r_state;
  logic [1:0]       r_slot;
  logic [3:0][55:0] r_subs;
  logic [3:0]       r_mask, r_bflag, r_sub_err;
  logic [55:0]      w_cur;
  logic             w_slot_live, w_par_fail;
  logic [FW-1:0]    w_push_data, w_fifo_dout;
  logic             w_fifo_empty, w_fifo_full;

  assign w_cur       = r_subs[r_slot];
  assign w_slot_live = (r_state == ST_UNPACK) && r_mask[r_slot] && !r_sub_err[r_slot];
  assign w_push_data = {w_cur[47:48-W], w_cur[23:24-W], r_bflag[r_slot]};
  assign w_par_fail  = (^{w_cur[51:48], w_cur[23:0]}) | (^{w_cur[55:52], w_cur[47:24]});

  always_ff @(posedge i_clk_pixel or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_subs    <= '0;
      r_mask    <= '0;
      r_bflag   <= '0;
      r_sub_err <= '0;
    end else if (i_packet_valid) begin
      // Any new packet abandons slots still pending from the previous one.
      if (w_is_audio) begin
        r_state   <= ST_UNPACK;
        r_slot    <= '0;
        r_subs    <= i_sub;
        r_mask    <= w_hb1[3:0];
        r_bflag   <= w_hb2[7:4];
        r_sub_err <= i_sub_ecc_error;
      end else begin
        r_state <= ST_IDLE;
      end
    end else if (r_state == ST_UNPACK) begin
      r_slot <= r_slot + 1'b1;
      if (r_slot == 2'd3) r_state <= ST_IDLE;
    end
  end

  hdmi_rx_audio_fifo #(
    .WIDTH      (FW),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (i_clk_pixel),
    .i_rst   (i_reset),
    .i_push  (w_slot_live),
    .i_din   (w_push_data),
    .i_pop   (i_audio_ready),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign o_audio_valid          = !w_fifo_empty;
  assign o_audio_block_start    = w_fifo_dout[0];
  assign o_audio_sample_word[0] = w_fifo_dout[W:1];
  assign o_audio_sample_word[1] = w_fifo_dout[2*W:W+1];

  logic r_overflow, r_parity;

  always_ff @(posedge i_clk_pixel or posedge i_reset) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
      r_parity   <= 1'b0;
    end else begin
      if (w_slot_live && w_par_fail) r_parity <= 1'b1;
      if (w_slot_live && w_fifo_full && !i_audio_ready) r_overflow <= 1'b1;
    end
  end

  assign o_audio_overflow = r_overflow;
  assign o_parity_error   = r_parity;

  // AVI checksum: two partial byte sums, combined one cycle later.
  logic [7:0] w_sum_lo, w_sum_hi, w_avi_sum;
  logic [7:0] r_avi_sum_lo, r_avi_sum_hi;
  logic [6:0] r_avi_vic_s1;
  logic       r_avi_vld;

  always_comb begin
    w_sum_lo = w_hb0 + w_hb1 + w_hb2;
    w_sum_hi = '0;
    for (int n = 0; n < 7; n++) begin
      w_sum_lo = w_sum_lo + sub_byte(i_sub[0], n) + sub_byte(i_sub[1], n);
      w_sum_hi = w_sum_hi + sub_byte(i_sub[2], n) + sub_byte(i_sub[3], n);
    end
  end

  assign w_avi_sum = r_avi_sum_lo + r_avi_sum_hi;

  logic [19:0] r_acr_n, r_acr_cts;
  logic        r_acr_update;
  logic [6:0]  r_avi_vic;
  logic        r_avi_valid;
  logic [15:0] r_ecc_cnt;

  always_ff @(posedge i_clk_pixel or posedge i_reset) begin
    if (i_reset) begin
      r_acr_n      <= '0;
      r_acr_cts    <= '0;
      r_acr_update <= 1'b0;
      r_avi_sum_lo <= '0;
      r_avi_sum_hi <= '0;
      r_avi_vic_s1 <= '0;
      r_avi_vld    <= 1'b0;
      r_avi_vic    <= '0;
      r_avi_valid  <= 1'b0;
      r_ecc_cnt    <= '0;
    end else begin
      r_acr_update <= w_is_acr;
      if (w_is_acr) begin
        r_acr_cts <= {i_sub[0][11:8], i_sub[0][23:16], i_sub[0][31:24]};
        r_acr_n   <= {i_sub[0][35:32], i_sub[0][47:40], i_sub[0][55:48]};
      end
      r_avi_vld <= w_is_avi;
      if (w_is_avi) begin
        r_avi_sum_lo <= w_sum_lo;
        r_avi_sum_hi <= w_sum_hi;
        r_avi_vic_s1 <= i_sub[0][38:32];
      end
      if (r_avi_vld && (w_avi_sum == 8'h00)) begin
        r_avi_vic   <= r_avi_vic_s1;
        r_avi_valid <= 1'b1;
      end
      if (i_packet_valid && (i_header_ecc_error || (|i_sub_ecc_error)) &&
          (r_ecc_cnt != 16'hFFFF))
        r_ecc_cnt <= r_ecc_cnt + 1'b1;
    end
  end

  assign o_acr_n           = r_acr_n;
  assign o_acr_cts         = r_acr_cts;
  assign o_acr_update      = r_acr_update;
  assign o_avi_vic         = r_avi_vic;
  assign o_avi_valid       = r_avi_valid;
  assign o_ecc_error_count = r_ecc_cnt;

endmodule
